// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and the board logic. The write side
// uses the receiver's valid/ack_n handshake; the read side is first-word-fall-through.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ack_n,
  input  logic          flush,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        armed_q, armed_d;
  logic        ack_n_q, ack_n_d;
  logic        capture;
  logic        pop;

  // Status is derived only from registered pointers, so a same-cycle pop
  // never opens room for a capture while the FIFO reads as full.
  always_comb begin
    level = wr_ptr_q - rd_ptr_q;
    empty = (level == '0);
    full  = (level == FULL_LVL);
  end

  always_comb begin
    capture = armed_q && rx_valid && !full && !flush;
    pop     = rd_en && !empty && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (capture) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // The receiver keeps rx_valid high for a while after the ack, so we only
  // re-arm once it has been seen low; flush leaves the handshake alone.
  always_comb begin
    armed_d = armed_q;
    if (capture) begin
      armed_d = 1'b0;
    end else if (!rx_valid) begin
      armed_d = 1'b1;
    end
    ack_n_d = !capture;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      armed_q  <= 1'b0;
      ack_n_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      armed_q  <= armed_d;
      ack_n_q  <= ack_n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst && capture) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_ack_n = ack_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a byte queue model fed by the sender,
// checked by a negedge monitor against every pop and the status outputs.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          nrst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ack_n;
  logic          flush;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   level;

  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  bit            done   = 1'b0;
  logic [7:0]    cur_byte;
  logic [7:0]    model_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack_n (rx_ack_n),
    .flush    (flush),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .level    (level)
  );

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behaves like the UART receiver: hold the byte until ack, then keep
  // rx_valid high for two more sampled edges before dropping it.
  task automatic send_byte(input logic [7:0] b, input int max_wait);
    bit got;
    got      = 1'b0;
    cur_byte = b;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < max_wait && !got; n++) begin
      cyc(1);
      if (rx_ack_n === 1'b0) got = 1'b1;
    end
    chk(got, "ack_timeout", int'(got), 1);
    if (got) begin
      cyc(1);
      chk(rx_ack_n === 1'b1, "ack_width", int'(rx_ack_n), 1);
      cyc(1);
      chk(rx_ack_n === 1'b1, "no_double_ack", int'(rx_ack_n), 1);
    end
    rx_valid = 1'b0;
    cyc(1);
  endtask

  // Scoreboard: an accepted byte enters the queue when its ack is seen;
  // pops, flush and reset act on the queue at the edge they are sampled for.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [AW:0] exp_lvl;
      if (rx_ack_n === 1'b0) model_q.push_back(cur_byte);
      exp_lvl = (AW + 1)'(model_q.size());
      chk(level === exp_lvl, "level", int'(level), int'(exp_lvl));
      chk(empty === (model_q.size() == 0), "empty", int'(empty), int'(model_q.size() == 0));
      chk(full === (model_q.size() == DEPTH), "full", int'(full), int'(model_q.size() == DEPTH));
      if (nrst && !flush && rd_en && model_q.size() > 0) begin
        chk(rd_data === model_q[0], "pop_data", int'(rd_data), int'(model_q[0]));
        void'(model_q.pop_front());
      end
      if (!nrst || flush) model_q.delete();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    nrst     = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    flush    = 1'b0;
    rd_en    = 1'b0;
    cur_byte = 8'h00;

    cyc(2);
    chk(empty === 1'b1, "rst_empty", int'(empty), 1);
    chk(full === 1'b0, "rst_full", int'(full), 0);
    chk(level === '0, "rst_level", int'(level), 0);
    chk(rx_ack_n === 1'b1, "rst_ack", int'(rx_ack_n), 1);
    nrst   = 1'b1;
    mon_en = 1'b1;
    cyc(1);

    // single byte, exact handshake timing
    cur_byte = 8'hA5;
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    cyc(1);
    chk(rx_ack_n === 1'b0, "t1_ack_low", int'(rx_ack_n), 0);
    chk(empty === 1'b0, "t1_empty", int'(empty), 0);
    chk(rd_data === 8'hA5, "t1_rd_data", int'(rd_data), 'hA5);
    cyc(1);
    chk(rx_ack_n === 1'b1, "t1_ack_width", int'(rx_ack_n), 1);
    cyc(1);
    chk(rx_ack_n === 1'b1, "t1_no_second_ack", int'(rx_ack_n), 1);
    rx_valid = 1'b0;
    cyc(2);
    chk(level === 5'd1, "t1_level", int'(level), 1);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    chk(empty === 1'b1, "t1_empty_after_pop", int'(empty), 1);

    // fill, then back-pressure
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 20);
    chk(full === 1'b1, "t2_full", int'(full), 1);
    chk(level === 5'd16, "t2_level", int'(level), 16);
    cur_byte = 8'h10;
    rx_data  = 8'h10;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      chk(rx_ack_n === 1'b1, "t2_ack_held", int'(rx_ack_n), 1);
    end
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    chk(rx_ack_n === 1'b1, "t2_no_ack_on_pop_edge", int'(rx_ack_n), 1);
    chk(full === 1'b0, "t2_not_full", int'(full), 0);
    cyc(1);
    chk(rx_ack_n === 1'b0, "t2_ack_after_pop", int'(rx_ack_n), 0);
    chk(full === 1'b1, "t2_full_again", int'(full), 1);
    cyc(1);
    chk(rx_ack_n === 1'b1, "t2_ack_width", int'(rx_ack_n), 1);
    cyc(1);
    rx_valid = 1'b0;
    cyc(1);

    // drain across pointer wrap, then pop on empty
    rd_en = 1'b1;
    cyc(DEPTH);
    rd_en = 1'b0;
    chk(empty === 1'b1, "t3_empty", int'(empty), 1);
    rd_en = 1'b1;
    cyc(2);
    rd_en = 1'b0;
    chk(level === '0, "t3_level_after_extra_pop", int'(level), 0);
    chk(empty === 1'b1, "t3_empty_after_extra_pop", int'(empty), 1);

    // simultaneous capture and pop at level 5
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 20);
    chk(level === 5'd5, "t4_level_before", int'(level), 5);
    b        = 8'($urandom_range(0, 255));
    cur_byte = b;
    rx_data  = b;
    rx_valid = 1'b1;
    rd_en    = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    chk(rx_ack_n === 1'b0, "t4_ack", int'(rx_ack_n), 0);
    chk(level === 5'd5, "t4_level_after", int'(level), 5);
    cyc(2);
    rx_valid = 1'b0;
    cyc(1);
    rd_en = 1'b1;
    cyc(5);
    rd_en = 1'b0;
    chk(empty === 1'b1, "t4_drained", int'(empty), 1);

    // flush at level 7 with an ack pulse in flight
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 20);
    cur_byte = 8'h5A;
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    cyc(1);
    chk(rx_ack_n === 1'b0, "t5_ack_low", int'(rx_ack_n), 0);
    chk(level === 5'd7, "t5_level7", int'(level), 7);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk(level === '0, "t5_level_flushed", int'(level), 0);
    chk(empty === 1'b1, "t5_empty_flushed", int'(empty), 1);
    chk(rx_ack_n === 1'b1, "t5_ack_completed", int'(rx_ack_n), 1);
    cyc(1);
    chk(rx_ack_n === 1'b1, "t5_no_recapture", int'(rx_ack_n), 1);
    rx_valid = 1'b0;
    cyc(1);

    // reset mid-transfer with rx_valid held through release
    cur_byte = 8'h77;
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    cyc(1);
    chk(rx_ack_n === 1'b0, "t6_ack_before_rst", int'(rx_ack_n), 0);
    nrst = 1'b0;
    cyc(1);
    chk(rx_ack_n === 1'b1, "t6_ack_cancelled", int'(rx_ack_n), 1);
    chk(level === '0, "t6_level_rst", int'(level), 0);
    cyc(2);
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk(rx_ack_n === 1'b1, "t6_no_capture_held", int'(rx_ack_n), 1);
    end
    rx_valid = 1'b0;
    cyc(1);
    send_byte(8'h3C, 20);
    chk(level === 5'd1, "t6_level", int'(level), 1);
    chk(rd_data === 8'h3C, "t6_rd_data", int'(rd_data), 'h3C);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;

    // random traffic with a random consumer
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          cyc($urandom_range(0, 3));
          send_byte(8'($urandom_range(0, 255)), 400);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rd_en = ($urandom_range(0, 2) == 0);
          cyc(1);
        end
        rd_en = 1'b0;
      end
    join
    rd_en = 1'b1;
    cyc(DEPTH + 4);
    rd_en = 1'b0;
    cyc(1);
    chk(empty === 1'b1, "t7_empty", int'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
